// File: rtl/fact_pkg.sv
// Shared types and default sizing for the factorial engine.
package fact_pkg;

  localparam int FACT_WIDTH = 32;  // result / accumulator width
  localparam int FACT_N_W   = 4;   // operand width

  // Control FSM states
  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_t;

endpackage

// File: rtl/fact_dp.sv
// Factorial datapath: accumulator, down-counter, widened multiplier,
// overflow detect and the committed result register.
module fact_dp
  import fact_pkg::*;
#(
  parameter int WIDTH = FACT_WIDTH,
  parameter int N_W   = FACT_N_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,    // start: acc=1, cnt=n
  input  logic             step,    // acc*=cnt, cnt--
  input  logic             commit,  // publish acc as result
  input  logic [N_W-1:0]   n,
  output logic             last,    // cnt<=1, nothing left to multiply
  output logic             ovf,     // current product does not fit WIDTH
  output logic [WIDTH-1:0] result
);

  localparam int PW = WIDTH + N_W;

  logic [WIDTH-1:0] acc;
  logic [N_W-1:0]   cnt;
  logic [PW-1:0]    prod;

  // Full-width product so any carry past WIDTH is visible as overflow
  assign prod = PW'(acc) * PW'(cnt);
  assign ovf  = |prod[PW-1:WIDTH];
  assign last = (cnt <= N_W'(1));

  // Accumulator and counter: reload on start, multiply-and-count on step
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= WIDTH'(1);
      cnt <= '0;
    end else if (load) begin
      acc <= WIDTH'(1);
      cnt <= n;
    end else if (step) begin
      acc <= prod[WIDTH-1:0];
      cnt <= cnt - N_W'(1);
    end
  end

  // Result only moves on a clean completion; abort/overflow leave it alone
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         result <= '0;
    else if (commit) result <= acc;
  end

endmodule

// File: rtl/fact_engine.sv
// Iterative factorial engine: IDLE/MUL control FSM driving fact_dp,
// with level done/error status held until the next accepted start.
module fact_engine
  import fact_pkg::*;
#(
  parameter int WIDTH = FACT_WIDTH,
  parameter int N_W   = FACT_N_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic             abort,
  input  logic [N_W-1:0]   n,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [WIDTH-1:0] result
);

  state_t state_q, state_d;
  logic   load, step, commit, fail;
  logic   last, ovf;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state: leave MUL on abort, completion or overflow
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (go) state_d = MUL;
      MUL:  if (abort || last || ovf) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath strobes; abort outranks completion, completion outranks overflow
  always_comb begin
    load   = 1'b0;
    step   = 1'b0;
    commit = 1'b0;
    fail   = 1'b0;
    unique case (state_q)
      IDLE: load = go;
      MUL: begin
        if (!abort) begin
          if (last)     commit = 1'b1;
          else if (ovf) fail   = 1'b1;
          else          step   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Status flags: cleared on start, set exclusively on the ending edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done  <= 1'b0;
      error <= 1'b0;
    end else if (load) begin
      done  <= 1'b0;
      error <= 1'b0;
    end else if (commit) begin
      done  <= 1'b1;
    end else if (fail) begin
      error <= 1'b1;
    end
  end

  assign busy = (state_q == MUL);

  fact_dp #(
    .WIDTH (WIDTH),
    .N_W   (N_W)
  ) u_dp (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .step   (step),
    .commit (commit),
    .n      (n),
    .last   (last),
    .ovf    (ovf),
    .result (result)
  );

endmodule

// File: tb/tb_fact_engine.sv
// Directed bench for fact_engine with a factorial reference model.
module tb_fact_engine;

  localparam int WIDTH = 32;
  localparam int N_W   = 4;
  localparam longint MAXV = 64'h0000_0000_FFFF_FFFF;

  logic             clk, rst, go, abort;
  logic [N_W-1:0]   n;
  logic             busy, done, error;
  logic [WIDTH-1:0] result;

  int total = 0;
  int bad   = 0;

  fact_engine #(.WIDTH(WIDTH), .N_W(N_W)) dut (
    .clk(clk), .rst(rst), .go(go), .abort(abort), .n(n),
    .busy(busy), .done(done), .error(error), .result(result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  // ---- reference model: outcome of a run from the factorial arithmetic ----
  function automatic longint fact_of(input int nv);
    longint p;
    p = 1;
    for (int i = 2; i <= nv; i++) p = p * i;
    return p;
  endfunction

  // Number of multiplies (n, n-1, ... 2) until the running product exceeds WIDTH; 0 if never
  function automatic int ovf_step(input int nv);
    longint p;
    p = 1;
    for (int k = 1; k < nv; k++) begin
      p = p * (nv - k + 1);
      if (p > MAXV) return k;
    end
    return 0;
  endfunction

  function automatic int lat_of(input int nv);
    int ov;
    ov = ovf_step(nv);
    if (ov != 0) return ov;
    return (nv < 1) ? 1 : nv;
  endfunction

  logic        mbusy, mdone, merr, perr;
  logic [31:0] mres, pres;
  int          mrem;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mbusy <= 0; mdone <= 0; merr <= 0; mres <= 0; mrem <= 0;
      perr  <= 0; pres <= 0;
    end else if (!mbusy) begin
      if (go) begin
        mbusy <= 1; mdone <= 0; merr <= 0;
        mrem  <= lat_of(int'(n));
        perr  <= (ovf_step(int'(n)) != 0);
        pres  <= 32'(fact_of(int'(n)));
      end
    end else if (abort) begin
      mbusy <= 0;
    end else if (mrem == 1) begin
      mbusy <= 0;
      if (perr) merr <= 1;
      else begin mdone <= 1; mres <= pres; end
    end else begin
      mrem <= mrem - 1;
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    chk("busy", busy, mbusy);
    chk("done", done, mdone);
    chk("error", error, merr);
    chk("result", result, mres);
    chk("done_and_error_exclusive", done & error, 0);
  end

  // ---- stimulus helpers ----
  task automatic start(input int nv);
    @(negedge clk);
    go = 1; n = N_W'(nv);
    @(negedge clk);
    go = 0; n = N_W'($urandom_range(0, 15));  // later n must not matter
  endtask

  task automatic run_wait(output int cyc);
    cyc = 0;
    while (busy && cyc < 40) begin
      cyc++;
      @(negedge clk);
    end
    chk("idle_within_bound", busy, 0);
  endtask

  int cyc;

  initial begin
    rst = 1; go = 0; abort = 0; n = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_result", result, 0);
    rst = 0;

    // n=5
    start(5); run_wait(cyc);
    chk("n5_cycles", cyc, 5);
    chk("n5_result", result, 120);
    chk("n5_done", done, 1);

    // n=0 and n=1 both finish in one cycle with 1
    start(0); run_wait(cyc);
    chk("n0_cycles", cyc, 1);
    chk("n0_result", result, 1);
    start(1); run_wait(cyc);
    chk("n1_cycles", cyc, 1);
    chk("n1_result", result, 1);

    // n=12 is the largest that fits 32 bits
    start(12); run_wait(cyc);
    chk("n12_cycles", cyc, 12);
    chk("n12_result", result, 479001600);

    // n=13 overflows on the last multiply, result keeps 120
    start(5); run_wait(cyc);
    start(13); run_wait(cyc);
    chk("n13_cycles", cyc, 12);
    chk("n13_error", error, 1);
    chk("n13_done", done, 0);
    chk("n13_result", result, 120);

    // abort in cycle 4 of n=10, then n=3
    start(10);
    repeat (3) @(negedge clk);
    abort = 1;
    @(negedge clk);
    abort = 0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_error", error, 0);
    chk("abort_result", result, 120);
    start(3); run_wait(cyc);
    chk("n3_cycles", cyc, 3);
    chk("n3_result", result, 6);

    // go held across completion: re-accepted one edge after returning to IDLE
    @(negedge clk);
    go = 1; n = 4'd2;
    @(negedge clk); chk("b2b_busy_e0", busy, 1);
    @(negedge clk); chk("b2b_busy_e1", busy, 1);
    @(negedge clk);
    chk("b2b_idle_e2", busy, 0);
    chk("b2b_done_e2", done, 1);
    chk("b2b_result_e2", result, 2);
    @(negedge clk);
    go = 0;
    chk("b2b_busy_e3", busy, 1);
    chk("b2b_done_e3", done, 0);
    run_wait(cyc);

    // abort in IDLE is inert
    abort = 1;
    repeat (2) @(negedge clk);
    abort = 0;
    chk("idle_abort_done", done, 1);
    chk("idle_abort_result", result, 2);

    // abort beats completion (n=1) and overflow (n=13, cycle 12)
    start(1);
    abort = 1;
    @(negedge clk);
    abort = 0;
    chk("abort_vs_done_done", done, 0);
    chk("abort_vs_done_result", result, 2);
    start(13);
    repeat (11) @(negedge clk);
    abort = 1;
    @(negedge clk);
    abort = 0;
    chk("abort_vs_ovf_error", error, 0);
    chk("abort_vs_ovf_busy", busy, 0);

    // go during MUL is dropped, not queued
    start(3);
    go = 1; n = 4'd5;
    @(negedge clk);
    go = 0;
    run_wait(cyc);
    chk("ignored_go_result", result, 6);
    @(negedge clk);
    chk("ignored_go_no_restart", busy, 0);

    // n=9 with stray go in cycle 2 and async reset mid cycle 3
    start(9);
    go = 1; n = 4'd3;
    @(negedge clk);
    go = 0;
    #2 rst = 1;
    #1;
    chk("async_rst_busy", busy, 0);
    chk("async_rst_result", result, 0);
    chk("async_rst_done", done, 0);
    @(negedge clk);
    rst = 0;

    // first go after reset is accepted immediately
    start(4);
    chk("post_rst_busy", busy, 1);
    run_wait(cyc);
    chk("post_rst_cycles", cyc, 4);
    chk("post_rst_result", result, 24);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fact_engine.md
FACT_ENGINE -- requirements
Module: fact_engine

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning result and accumulator width in bits (legal range 8..64).
REQ-002 SHALL have parameter N_W, default 4, meaning operand width in bits (legal range 1..8).
REQ-003 SHALL have port clk  input  1  sole clock, rising-edge.
REQ-004 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-005 SHALL have port go  input  1  start request, sampled on clk.
REQ-006 SHALL have port abort  input  1  cancel the running computation.
REQ-007 SHALL have port n  input  N_W  operand; factorial argument.
REQ-008 SHALL have port busy  output  1  computation in progress.
REQ-009 SHALL have port done  output  1  last computation completed without overflow; level.
REQ-010 SHALL have port error  output  1  last computation overflowed WIDTH; level.
REQ-011 SHALL have port result  output  WIDTH  n! of the last successful computation.

Function
REQ-012 SHALL implement a two-state FSM: IDLE and MUL.
REQ-013 In IDLE, go=1 SHALL be accepted on the next edge:
- cnt <= n, acc <= 1
- done <= 0, error <= 0
- next state MUL
REQ-014 In MUL with cnt > 1 and abort=0, each edge SHALL perform:
- acc <= low WIDTH bits of acc*cnt
- cnt <= cnt-1
REQ-015 The product SHALL be formed at WIDTH+N_W bits; any nonzero bit above WIDTH-1 SHALL be an overflow.
REQ-016 On an overflowing edge the FSM SHALL return to IDLE with error <= 1, done <= 0 and result unchanged.
REQ-017 In MUL with cnt <= 1 and abort=0, the next edge SHALL return to IDLE with result <= acc, done <= 1 and error <= 0.
REQ-018 Latency from the accepting edge to done=1 SHALL be max(n,1) cycles, so n=0 and n=1 both yield result=1.
REQ-019 abort=1 in MUL SHALL return to IDLE on the next edge with done=0, error=0, result unchanged, and SHALL take priority over completion and overflow.
REQ-020 abort=1 in IDLE SHALL have no effect.
REQ-021 go while in MUL SHALL be ignored, with no queuing.
REQ-022 n SHALL be sampled only on the accepting edge; later changes to n SHALL NOT affect the running computation.
REQ-023 busy SHALL equal (state==MUL) and SHALL be registered-state derived, with no combinational path from go.
REQ-024 done, error and result SHALL be registers that hold their values in IDLE until the next accepted go or reset.
REQ-025 done and error SHALL never be 1 simultaneously.
REQ-026 A back-to-back go asserted on the same edge that returns the FSM to IDLE SHALL be accepted on the following edge, not on the returning edge.

Reset
REQ-027 rst=1 SHALL immediately force, regardless of clk:
- state=IDLE
- acc=1, cnt=0
- result=0
- busy=0, done=0, error=0
REQ-028 rst asserted mid-computation SHALL discard the computation, with no output retaining pre-reset values.
REQ-029 The first go after rst deasserts SHALL be accepted on the first clk edge that samples it.

Structure
REQ-030 Shared package fact_pkg SHALL hold:
- the state enum (IDLE, MUL)
- default WIDTH and N_W constants
REQ-031 A single sub-module fact_dp SHALL hold:
- acc and cnt registers
- the WIDTH+N_W multiplier
- the overflow compare and cnt<=1 compare
REQ-032 fact_dp SHALL be controlled by load, step and commit strobes from the fact_engine FSM.

Verification (WIDTH=32, N_W=4)
REQ-033 Scenario: go with n=5 -> busy for 5 cycles, then done=1, result=120, error=0.
REQ-034 Scenario: go with n=0, then go with n=1 -> each gives done=1, result=1, one cycle after acceptance.
REQ-035 Scenario: go with n=12 -> done=1, result=479001600 after 12 cycles.
REQ-036 Scenario: go with n=13 after a successful n=5 -> error=1, done=0 after 12 cycles, and result still 120 (13! = 6227020800 overflows on the last multiply).
REQ-037 Scenario: go with n=10, then abort in cycle 4 -> IDLE next edge with done=0, error=0, result unchanged; then go with n=3 -> result=6.
REQ-038 Scenario: go with n=9, then rst asserted between edges in cycle 3 -> outputs reset immediately, asynchronously; go re-sent in cycle 2 during the run -> ignored (REQ-021).
